// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared types for the RV32 5-stage pipeline controller.
//   pc_sel_e     : PC source select driven to the fetch stage
//   pipe_state_e : sequencer FSM states
//   PIPE_STAGES  : number of pipeline stages (F/D/E/M/W)
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int PIPE_STAGES = 5;

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_TRAP     = 2'd2
  } pc_sel_e;

  typedef enum logic [2:0] {
    RST_HOLD,
    RUN,
    MEM_WAIT,
    MDU_WAIT,
    TRAP
  } pipe_state_e;

endpackage

// File: rtl/riscv_sat_counter.sv
// ---------------------------------------------------------------------------
// riscv_sat_counter
// Saturating up-counter used for the pipeline performance counters. Sticks
// at all-ones instead of wrapping.
// Ports:
//   clk   in         core clock
//   rst_n in         asynchronous active-low reset (count -> 0)
//   inc   in         increment request for this cycle
//   count out CNT_W  current count
// ---------------------------------------------------------------------------
module riscv_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: hold unless incrementing, and never roll past all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_pipeline_ctrl
// Central stall/flush sequencer for the 5-stage RV32 core. Merges load-use
// hazards, E-stage redirects, data-memory wait states, multi-cycle MDU ops
// and trap requests into per-stage stall/flush enables and the PC select.
// All outputs are combinational from the FSM state and the inputs.
//
// Optional feature macro: RISCV_PIPE_PERF_CNT_EN
//   defined   : stall_cycles / flush_events are saturating counters
//   undefined : both counters are tied to zero, no counter flops
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_use_hazard     D-stage instruction depends on a load in E
//   branch_taken        E-stage branch resolved taken
//   jump_taken          E-stage JAL/JALR
//   mdu_start_e         multi-cycle MDU op issued in E
//   mdu_done            MDU result valid (pulse)
//   dmem_req_m          M-stage load/store active
//   dmem_ready_m        data memory completes the M-stage access
//   trap_req            exception/interrupt request (pulse)
//   stall_f/d/e/m       hold the stage register
//   flush_d/e/m/w       insert a bubble into the stage register
//   pc_sel              PC_SEQ / PC_REDIRECT / PC_TRAP
//   bus_err             one-cycle pulse on data-memory timeout
//   stall_cycles        cycles with stall_f high (outside RST_HOLD)
//   flush_events        redirects plus trap entries
// ---------------------------------------------------------------------------
module riscv_pipeline_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 64,
  parameter int TRAP_FLUSH_CYC = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             jump_taken,
  input  logic             mdu_start_e,
  input  logic             mdu_done,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  input  logic             trap_req,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [1:0]       pc_sel,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Stall vector bit order is {F, D, E, M}; flush vector is {D, E, M, W}.
  localparam logic [PIPE_STAGES-2:0] STALL_NONE  = 4'b0000;
  localparam logic [PIPE_STAGES-2:0] STALL_FRONT = 4'b1000;
  localparam logic [PIPE_STAGES-2:0] STALL_FD    = 4'b1100;
  localparam logic [PIPE_STAGES-2:0] STALL_FDE   = 4'b1110;
  localparam logic [PIPE_STAGES-2:0] STALL_ALL   = 4'b1111;

  localparam logic [PIPE_STAGES-2:0] FLUSH_NONE  = 4'b0000;
  localparam logic [PIPE_STAGES-2:0] FLUSH_ALL   = 4'b1111;
  localparam logic [PIPE_STAGES-2:0] FLUSH_DEM   = 4'b1110;
  localparam logic [PIPE_STAGES-2:0] FLUSH_DE    = 4'b1100;
  localparam logic [PIPE_STAGES-2:0] FLUSH_E     = 4'b0100;
  localparam logic [PIPE_STAGES-2:0] FLUSH_M     = 4'b0010;
  localparam logic [PIPE_STAGES-2:0] FLUSH_W     = 4'b0001;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [2:0] TRAP_LOAD  = 3'(TRAP_FLUSH_CYC);

  pipe_state_e state_q, state_d;
  logic        trap_pending_q, trap_pending_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  trap_cnt_q, trap_cnt_d;
  logic        mdu_done_q, mdu_done_d;

  logic [PIPE_STAGES-2:0] stall_vec;
  logic [PIPE_STAGES-2:0] flush_vec;
  pc_sel_e                pc_sel_int;
  logic                   bus_err_int;
  logic                   dmem_stall;

  assign dmem_stall = dmem_req_m & ~dmem_ready_m;

  // State, pending trap, wait/trap counters. mdu_done_q remembers an MDU
  // completion that arrived while a memory stall was holding MDU_WAIT, so
  // the single-cycle done pulse is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RST_HOLD;
      trap_pending_q <= 1'b0;
      wait_cnt_q     <= '0;
      trap_cnt_q     <= '0;
      mdu_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      trap_pending_q <= trap_pending_d;
      wait_cnt_q     <= wait_cnt_d;
      trap_cnt_q     <= trap_cnt_d;
      mdu_done_q     <= mdu_done_d;
    end
  end

  // Next-state and output decode. RUN applies a strict priority: trap,
  // memory stall, MDU start, redirect, load-use bubble. Outside RUN any
  // trap request is merged into the single pending trap and taken on the
  // first RUN cycle. The memory timeout path re-uses that pending flag so
  // the bus error becomes a trap on the following RUN cycle.
  always_comb begin
    state_d        = state_q;
    trap_pending_d = trap_pending_q;
    wait_cnt_d     = wait_cnt_q;
    trap_cnt_d     = trap_cnt_q;
    mdu_done_d     = mdu_done_q;
    stall_vec      = STALL_NONE;
    flush_vec      = FLUSH_NONE;
    pc_sel_int     = PC_SEQ;
    bus_err_int    = 1'b0;

    case (state_q)
      RST_HOLD: begin
        stall_vec      = STALL_FRONT;
        flush_vec      = FLUSH_ALL;
        trap_pending_d = trap_pending_q | trap_req;
        state_d        = RUN;
      end

      RUN: begin
        wait_cnt_d = '0;
        mdu_done_d = 1'b0;
        if (trap_pending_q || trap_req) begin
          flush_vec      = FLUSH_DEM;
          pc_sel_int     = PC_TRAP;
          trap_pending_d = 1'b0;
          trap_cnt_d     = TRAP_LOAD;
          state_d        = TRAP;
        end else if (dmem_stall) begin
          stall_vec  = STALL_ALL;
          flush_vec  = FLUSH_W;
          wait_cnt_d = 8'd1;
          state_d    = MEM_WAIT;
        end else if (mdu_start_e) begin
          stall_vec = STALL_FDE;
          flush_vec = FLUSH_M;
          state_d   = MDU_WAIT;
        end else if (branch_taken || jump_taken) begin
          flush_vec  = FLUSH_DE;
          pc_sel_int = PC_REDIRECT;
        end else if (load_use_hazard) begin
          stall_vec = STALL_FD;
          flush_vec = FLUSH_E;
        end
      end

      MEM_WAIT: begin
        trap_pending_d = trap_pending_q | trap_req;
        if (dmem_stall) begin
          stall_vec = STALL_ALL;
          flush_vec = FLUSH_W;
          if (wait_cnt_q == WAIT_LIMIT) begin
            bus_err_int    = 1'b1;
            trap_pending_d = 1'b1;
            wait_cnt_d     = '0;
            state_d        = RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end

      MDU_WAIT: begin
        trap_pending_d = trap_pending_q | trap_req;
        if (dmem_stall) begin
          stall_vec  = STALL_ALL;
          flush_vec  = FLUSH_W;
          mdu_done_d = mdu_done_q | mdu_done;
          if (wait_cnt_q == WAIT_LIMIT) begin
            bus_err_int    = 1'b1;
            trap_pending_d = 1'b1;
            wait_cnt_d     = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = '0;
          if (mdu_done || mdu_done_q) begin
            mdu_done_d = 1'b0;
            state_d    = RUN;
          end else begin
            stall_vec = STALL_FDE;
            flush_vec = FLUSH_M;
          end
        end
      end

      TRAP: begin
        stall_vec      = STALL_FRONT;
        flush_vec      = FLUSH_DEM;
        trap_pending_d = trap_pending_q | trap_req;
        if (trap_cnt_q <= 3'd1) begin
          trap_cnt_d = '0;
          state_d    = RUN;
        end else begin
          trap_cnt_d = trap_cnt_q - 3'd1;
        end
      end

      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  assign {stall_f, stall_d, stall_e, stall_m} = stall_vec;
  assign {flush_d, flush_e, flush_m, flush_w} = flush_vec;
  assign pc_sel  = pc_sel_int;
  assign bus_err = bus_err_int;

`ifdef RISCV_PIPE_PERF_CNT_EN
  // PC_REDIRECT and PC_TRAP are only ever selected on the cycle a redirect
  // or trap entry happens, so the PC select doubles as the event strobe.
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = stall_f && (state_q != RST_HOLD);
  assign flush_inc = (pc_sel_int == PC_REDIRECT) || (pc_sel_int == PC_TRAP);

  riscv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  riscv_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_pipeline_ctrl
// Directed-vector bench for riscv_pipeline_ctrl (MEM_TIMEOUT=8,
// TRAP_FLUSH_CYC=2). Each stimulus cycle pushes its hand-computed expected
// outputs into a scoreboard queue; a monitor pops and compares mid-cycle.
// ---------------------------------------------------------------------------
module tb_riscv_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_use_hazard;
  logic        branch_taken;
  logic        jump_taken;
  logic        mdu_start_e;
  logic        mdu_done;
  logic        dmem_req_m;
  logic        dmem_ready_m;
  logic        trap_req;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  pc_sel;
  logic        bus_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  int checkCount = 0;
  int failCount  = 0;

  // Stimulus bits: {rst_n, lu, br, jp, mdu_start, mdu_done, dreq, drdy, trap}
  localparam logic [8:0] R  = 9'h100;
  localparam logic [8:0] LU = 9'h080;
  localparam logic [8:0] BR = 9'h040;
  localparam logic [8:0] JP = 9'h020;
  localparam logic [8:0] MS = 9'h010;
  localparam logic [8:0] MD = 9'h008;
  localparam logic [8:0] DQ = 9'h004;
  localparam logic [8:0] DR = 9'h002;
  localparam logic [8:0] TR = 9'h001;

  // Expected output bits: {sf, sd, se, sm, fd, fe, fm, fw, pc_sel[1:0], bus_err}
  localparam logic [10:0] O_RESET = 11'b1000_1111_00_0;
  localparam logic [10:0] O_IDLE  = 11'b0000_0000_00_0;
  localparam logic [10:0] O_LU    = 11'b1100_0100_00_0;
  localparam logic [10:0] O_RED   = 11'b0000_1100_01_0;
  localparam logic [10:0] O_TTAKE = 11'b0000_1110_10_0;
  localparam logic [10:0] O_MEM   = 11'b1111_0001_00_0;
  localparam logic [10:0] O_BERR  = 11'b1111_0001_00_1;
  localparam logic [10:0] O_MDU   = 11'b1110_0010_00_0;
  localparam logic [10:0] O_TRAP  = 11'b1000_1110_00_0;

  typedef struct {
    logic [10:0] out;
    int          fe;
    string       nm;
  } exp_t;

  exp_t sb[$];

  riscv_pipeline_ctrl #(
    .MEM_TIMEOUT    (8),
    .TRAP_FLUSH_CYC (2),
    .CNT_W          (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .jump_taken      (jump_taken),
    .mdu_start_e     (mdu_start_e),
    .mdu_done        (mdu_done),
    .dmem_req_m      (dmem_req_m),
    .dmem_ready_m    (dmem_ready_m),
    .trap_req        (trap_req),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .stall_e         (stall_e),
    .stall_m         (stall_m),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .flush_m         (flush_m),
    .flush_w         (flush_w),
    .pc_sel          (pc_sel),
    .bus_err         (bus_err),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue what
  // the outputs must look like for that cycle. expFe < 0 skips the
  // flush-event counter comparison.
  task automatic applyStimulus(input logic [8:0] stim, input logic [10:0] expOut,
                               input int expFe, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    {rst_n, load_use_hazard, branch_taken, jump_taken, mdu_start_e,
     mdu_done, dmem_req_m, dmem_ready_m, trap_req} = stim;
    e.out = expOut;
    e.fe  = expFe;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Compare one scoreboard entry against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [10:0] act;
    int          feExp;
    act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           flush_w, pc_sel, bus_err};
    checkCount++;
    if (act !== e.out) begin
      failCount++;
      $display("[TB] FAIL %s: outputs got %b expected %b", e.nm, act, e.out);
    end
    if (e.fe >= 0) begin
`ifdef RISCV_PIPE_PERF_CNT_EN
      feExp = e.fe;
`else
      feExp = 0;
`endif
      checkCount++;
      if (flush_events !== 32'(feExp)) begin
        failCount++;
        $display("[TB] FAIL %s_flush_events: got %0d expected %0d",
                 e.nm, flush_events, feExp);
      end
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; sample it on
  // the falling edge whenever a pending expectation exists.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    {rst_n, load_use_hazard, branch_taken, jump_taken, mdu_start_e,
     mdu_done, dmem_req_m, dmem_ready_m, trap_req} = 9'h000;

    // Reset held for 3 cycles, then one RST_HOLD cycle, then RUN.
    for (int i = 0; i < 3; i++) applyStimulus(9'h000, O_RESET, -1, "reset_low");
    applyStimulus(R, O_RESET, -1, "rst_hold");
    applyStimulus(R, O_IDLE, 0, "run_idle");

    // Load-use bubble lasts one cycle; a redirect overrides it.
    applyStimulus(R | LU, O_LU, -1, "load_use");
    applyStimulus(R, O_IDLE, -1, "lu_single_bubble");
    applyStimulus(R | LU | BR, O_RED, -1, "lu_with_branch");
    applyStimulus(R | JP, O_RED, -1, "jump");
    applyStimulus(R, O_IDLE, 2, "after_redirects");

    // Memory wait: ready low 5 cycles, then high.
    for (int i = 0; i < 5; i++) applyStimulus(R | DQ, O_MEM, -1, "mem_wait");
    applyStimulus(R | DQ | DR, O_IDLE, -1, "mem_ready");
    applyStimulus(R, O_IDLE, -1, "after_mem");

    // Timeout: 8 wait cycles, bus error on the 9th, then trap entry.
    for (int i = 0; i < 8; i++) applyStimulus(R | DQ, O_MEM, -1, "timeout_wait");
    applyStimulus(R | DQ, O_BERR, -1, "bus_err_pulse");
    applyStimulus(R, O_TTAKE, -1, "timeout_trap");
    applyStimulus(R | BR | LU, O_TRAP, -1, "trap_ignores_branch");
    applyStimulus(R, O_TRAP, -1, "trap_cycle2");
    applyStimulus(R, O_IDLE, 3, "after_timeout_trap");

    // MDU op with a trap request on cycle 3 and done on cycle 10.
    applyStimulus(R | MS, O_MDU, -1, "mdu_start");
    applyStimulus(R, O_MDU, -1, "mdu_wait");
    applyStimulus(R | TR, O_MDU, -1, "mdu_trap_latched");
    for (int i = 0; i < 6; i++) applyStimulus(R, O_MDU, -1, "mdu_wait");
    applyStimulus(R | MD, O_IDLE, -1, "mdu_done");
    applyStimulus(R, O_TTAKE, -1, "mdu_trap_take");
    applyStimulus(R, O_TRAP, -1, "mdu_trap_c1");
    applyStimulus(R, O_TRAP, -1, "mdu_trap_c2");
    applyStimulus(R, O_IDLE, 4, "after_mdu_trap");

    // Memory stall inside MDU_WAIT dominates; done during it is remembered.
    applyStimulus(R | MS, O_MDU, -1, "mdu_start2");
    applyStimulus(R | DQ, O_MEM, -1, "mdu_mem_prio");
    applyStimulus(R | DQ | MD, O_MEM, -1, "mdu_done_in_mem");
    applyStimulus(R | DQ | DR, O_IDLE, -1, "mdu_mem_clear");
    applyStimulus(R, O_IDLE, 4, "after_mdu_mem");

    // Trap beats memory stall; memory stall beats branch.
    applyStimulus(R | TR | DQ, O_TTAKE, -1, "trap_over_mem");
    applyStimulus(R | DQ, O_TRAP, -1, "trap_holds_c1");
    applyStimulus(R | DQ, O_TRAP, -1, "trap_holds_c2");
    applyStimulus(R | DQ | DR, O_IDLE, 5, "mem_done_after_trap");
    applyStimulus(R | DQ | BR, O_MEM, -1, "mem_over_branch");
    applyStimulus(R | DQ | DR, O_IDLE, -1, "mem_over_branch_done");
    applyStimulus(R, O_IDLE, 5, "branch_not_counted");

    // Reset mid-MEM_WAIT with a trap pending: abandoned, no stale trap.
    applyStimulus(R | DQ, O_MEM, -1, "pre_reset_wait");
    applyStimulus(R | DQ | TR, O_MEM, -1, "pre_reset_trap");
    applyStimulus(DQ, O_RESET, -1, "reset_mid_wait");
    applyStimulus(DQ, O_RESET, -1, "reset_held");
    applyStimulus(R, O_RESET, -1, "rst_hold_again");
    applyStimulus(R, O_IDLE, 0, "no_stale_trap");
    applyStimulus(R, O_IDLE, -1, "final_idle");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
